// File: rtl/apb_arbiter_pkg.sv
// Shared types for the APB requester arbiter.
// State encoding, request latch layout, index helper.
package apb_arbiter_pkg;

  localparam int REQ_AW = 32;
  localparam int REQ_DW = 32;

  typedef enum logic [1:0] {
    APB_IDLE,
    APB_SETUP,
    APB_ACCESS
  } apb_state_e;

  typedef struct packed {
    logic [REQ_AW-1:0] addr;
    logic [REQ_DW-1:0] wdata;
    logic              we;
  } apb_req_t;

  // One-step modulo for indices already below 2*n.
  function automatic int wrap_idx(input int i, input int n);
    return (i >= n) ? i - n : i;
  endfunction

endpackage

// File: rtl/apb_arbiter_if.sv
// Requester req/gnt bundle plus shared APB bus.
// master = arbiter side, slave = requesters and crossbar.
interface apb_arbiter_if
  import apb_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int AW = REQ_AW,
  parameter int DW = REQ_DW
);

  logic [N-1:0]         req_i;
  logic [N-1:0]         we_i;
  logic [N-1:0][AW-1:0] addr_i;
  logic [N-1:0][DW-1:0] wdata_i;
  logic [N-1:0]         gnt_o;
  logic [N-1:0]         rvalid_o;
  logic [DW-1:0]        rdata_o;
  logic                 err_o;

  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic          PWRITE;
  logic          PSEL;
  logic          PENABLE;
  logic [DW-1:0] PRDATA;
  logic          PREADY;
  logic          PSLVERR;

  modport master (
    input  req_i, we_i, addr_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o, err_o,
    output PADDR, PWDATA, PWRITE,
    output PSEL, PENABLE,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    output req_i, we_i, addr_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o, err_o,
    input  PADDR, PWDATA, PWRITE,
    input  PSEL, PENABLE,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb_arbiter_rr.sv
// Round-robin picker; owns the rotating priority pointer.
// Winner is the first request at or after the pointer.
module apb_arbiter_rr
  import apb_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  gnt_onehot,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  logic [IW-1:0] ptr;

  // Scan from the pointer, wrapping, and keep the first hit.
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!any && req[IW'(wrap_idx(int'(ptr) + i, N))]) begin
        any     = 1'b1;
        gnt_idx = IW'(wrap_idx(int'(ptr) + i, N));
        gnt_onehot[IW'(wrap_idx(int'(ptr) + i, N))] = 1'b1;
      end
    end
  end

  // Move priority just past the requester that won.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      if (gnt_idx == IW'(N - 1)) ptr <= '0;
      else ptr <= gnt_idx + IW'(1);
    end
  end

endmodule

// File: rtl/apb_arbiter.sv
// Shares one APB master port among N requesters.
// Round-robin grant, SETUP/ACCESS sequencing, PREADY watchdog.
module apb_arbiter
  import apb_arbiter_pkg::*;
#(
  parameter int N_MASTERS      = 4,
  parameter int APB_DATA_WIDTH = REQ_DW,
  parameter int APB_ADDR_WIDTH = REQ_AW,
  parameter int TIMEOUT_CYC    = 255
) (
  input logic          PCLK,
  input logic          PRESET,
  apb_arbiter_if.master bus
);

  localparam int IW = $clog2(N_MASTERS);
  localparam int CW =
    (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  apb_state_e               state;
  apb_req_t                 cur;
  logic [N_MASTERS-1:0]     owner;
  logic [CW-1:0]            cnt;
  logic                     psel;
  logic                     penable;
  logic [N_MASTERS-1:0]     gnt;
  logic [N_MASTERS-1:0]     rvalid;
  logic [APB_DATA_WIDTH-1:0] rdata;
  logic                     err;

  logic [N_MASTERS-1:0] win_oh;
  logic [IW-1:0]        win_idx;
  logic                 any_req;
  logic                 tmo;
  logic                 done;
  logic                 advance;

  apb_arbiter_rr #(.N(N_MASTERS)) u_rr (
    .clk        (PCLK),
    .rst        (PRESET),
    .req        (bus.req_i),
    .advance    (advance),
    .gnt_onehot (win_oh),
    .gnt_idx    (win_idx),
    .any        (any_req)
  );

  assign tmo = (TIMEOUT_CYC != 0)
            && !bus.PREADY
            && (cnt == CW'(TIMEOUT_CYC - 1));
  assign done = (state == APB_ACCESS)
             && (bus.PREADY || tmo);
  assign advance = any_req
                && ((state == APB_IDLE) || done);

  assign bus.PADDR    = APB_ADDR_WIDTH'(cur.addr);
  assign bus.PWDATA   = APB_DATA_WIDTH'(cur.wdata);
  assign bus.PWRITE   = cur.we;
  assign bus.PSEL     = psel;
  assign bus.PENABLE  = penable;
  assign bus.gnt_o    = gnt;
  assign bus.rvalid_o = rvalid;
  assign bus.rdata_o  = rdata;
  assign bus.err_o    = err;

  // Transfer FSM; a grant overrides the completion's return to IDLE.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state   <= APB_IDLE;
      cur     <= '0;
      owner   <= '0;
      cnt     <= '0;
      psel    <= 1'b0;
      penable <= 1'b0;
      gnt     <= '0;
      rvalid  <= '0;
      rdata   <= '0;
      err     <= 1'b0;
    end else begin
      gnt    <= '0;
      rvalid <= '0;
      unique case (state)
        APB_IDLE: ;
        APB_SETUP: begin
          state   <= APB_ACCESS;
          penable <= 1'b1;
        end
        APB_ACCESS: begin
          if (!bus.PREADY && cnt != CW'(TIMEOUT_CYC))
            cnt <= cnt + CW'(1);
          if (done) begin
            rvalid  <= owner;
            rdata   <= (tmo || cur.we) ? '0 : bus.PRDATA;
            err     <= tmo || bus.PSLVERR;
            state   <= APB_IDLE;
            psel    <= 1'b0;
            penable <= 1'b0;
          end
        end
        default: state <= APB_IDLE;
      endcase
      if (advance) begin
        state     <= APB_SETUP;
        psel      <= 1'b1;
        penable   <= 1'b0;
        gnt       <= win_oh;
        owner     <= win_oh;
        cnt       <= '0;
        cur.addr  <= REQ_AW'(bus.addr_i[win_idx]);
        cur.wdata <= REQ_DW'(bus.wdata_i[win_idx]);
        cur.we    <= bus.we_i[win_idx];
      end
    end
  end

endmodule

// File: tb/tb_apb_arbiter.sv
// Directed vector bench for apb_arbiter.
// Timeout set to 4 so watchdog and long waits share one DUT.
module tb_apb_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  apb_arbiter_if #(.N(4), .AW(32), .DW(32)) bus ();

  apb_arbiter #(
    .N_MASTERS      (4),
    .APB_DATA_WIDTH (32),
    .APB_ADDR_WIDTH (32),
    .TIMEOUT_CYC    (4)
  ) dut (
    .PCLK   (clk),
    .PRESET (rst),
    .bus    (bus)
  );

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  we;
    logic        rdy;
    logic        serr;
    logic [31:0] prd;
    logic [3:0]  e_gnt;
    logic [3:0]  e_rv;
    logic        e_sel;
    logic        e_en;
    logic        e_wr;
    int          e_k;
    logic [31:0] e_rd;
    logic        e_err;
  } vec_t;

  localparam int NV = 31;
  vec_t v [NV];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [31:0] adr(input int k);
    return 32'h40 + 32'(k) * 32'h100;
  endfunction

  function automatic logic [31:0] wd(input int k);
    return 32'hC0DE_0000 + 32'(k);
  endfunction

  function automatic vec_t mk(
    input logic [3:0] req, input logic [3:0] we,
    input logic rdy, input logic serr,
    input logic [31:0] prd,
    input logic [3:0] g, input logic [3:0] rv,
    input logic sel, input logic en, input logic wr,
    input int k, input logic [31:0] rd, input logic er
  );
    vec_t r;
    r.req = req; r.we = we; r.rdy = rdy;
    r.serr = serr; r.prd = prd;
    r.e_gnt = g; r.e_rv = rv; r.e_sel = sel;
    r.e_en = en; r.e_wr = wr; r.e_k = k;
    r.e_rd = rd; r.e_err = er;
    return r;
  endfunction

  task automatic check(
    input string nm, input bit ok,
    input string act, input string req_s
  );
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got %s want %s", nm, act, req_s);
    end
  endtask

  function automatic string outs();
    return $sformatf(
      "g=%h rv=%h sel=%b en=%b wr=%b a=%h wd=%h rd=%h e=%b",
      bus.gnt_o, bus.rvalid_o, bus.PSEL, bus.PENABLE,
      bus.PWRITE, bus.PADDR, bus.PWDATA,
      bus.rdata_o, bus.err_o);
  endfunction

  task automatic drive(
    input logic [3:0] req, input logic [3:0] we,
    input logic rdy, input logic serr,
    input logic [31:0] prd
  );
    bus.req_i   = req;
    bus.we_i    = we;
    bus.PREADY  = rdy;
    bus.PSLVERR = serr;
    bus.PRDATA  = prd;
  endtask

  initial begin
    bit ok;
    for (int k = 0; k < 4; k++) begin
      bus.addr_i[k]  = adr(k);
      bus.wdata_i[k] = wd(k);
    end
    drive(4'h0, 4'h0, 1'b0, 1'b0, 32'h0);

    // all four requesting, grant order 0,1,2,3,0
    v[0]  = mk(4'hF,4'h0,0,0,32'h0,       4'h1,4'h0,1,0,0,0,32'h0,0);
    v[1]  = mk(4'hF,4'h0,1,0,32'h0,       4'h0,4'h0,1,1,0,0,32'h0,0);
    v[2]  = mk(4'hF,4'h0,1,0,32'h1111_0002,4'h2,4'h1,1,0,0,1,32'h1111_0002,0);
    v[3]  = mk(4'hF,4'h0,1,0,32'h0,       4'h0,4'h0,1,1,0,1,32'h0,0);
    v[4]  = mk(4'hF,4'h0,1,0,32'h1111_0004,4'h4,4'h2,1,0,0,2,32'h1111_0004,0);
    v[5]  = mk(4'hF,4'h0,1,0,32'h0,       4'h0,4'h0,1,1,0,2,32'h0,0);
    v[6]  = mk(4'hF,4'h0,1,0,32'h1111_0006,4'h8,4'h4,1,0,0,3,32'h1111_0006,0);
    v[7]  = mk(4'hF,4'h0,1,0,32'h0,       4'h0,4'h0,1,1,0,3,32'h0,0);
    v[8]  = mk(4'hF,4'h0,1,0,32'h1111_0008,4'h1,4'h8,1,0,0,0,32'h1111_0008,0);
    v[9]  = mk(4'h0,4'h0,1,0,32'h0,       4'h0,4'h0,1,1,0,0,32'h0,0);
    v[10] = mk(4'h0,4'h0,1,0,32'h1111_000A,4'h0,4'h1,0,0,0,0,32'h1111_000A,0);
    // single read from requester 0; PREADY/PSLVERR ignored in SETUP
    v[11] = mk(4'h1,4'h0,0,0,32'h0,       4'h1,4'h0,1,0,0,0,32'h0,0);
    v[12] = mk(4'h0,4'h0,1,1,32'h0,       4'h0,4'h0,1,1,0,0,32'h0,0);
    v[13] = mk(4'h0,4'h0,1,0,32'hDEAD_BEEF,4'h0,4'h1,0,0,0,0,32'hDEAD_BEEF,0);
    // pointer wrap: 3 granted, 1001 pending -> 0 next
    v[14] = mk(4'h8,4'h0,0,0,32'h0,       4'h8,4'h0,1,0,0,3,32'h0,0);
    v[15] = mk(4'h9,4'h0,0,0,32'h0,       4'h0,4'h0,1,1,0,3,32'h0,0);
    v[16] = mk(4'h9,4'h1,1,0,32'h2222_0010,4'h1,4'h8,1,0,1,0,32'h2222_0010,0);
    // write waits 3 cycles, finishes with PSLVERR
    v[17] = mk(4'h0,4'h0,0,0,32'h0,       4'h0,4'h0,1,1,1,0,32'h0,0);
    v[18] = mk(4'h0,4'h0,0,0,32'h0,       4'h0,4'h0,1,1,1,0,32'h0,0);
    v[19] = mk(4'h0,4'h0,0,0,32'h0,       4'h0,4'h0,1,1,1,0,32'h0,0);
    v[20] = mk(4'h0,4'h0,0,0,32'h0,       4'h0,4'h0,1,1,1,0,32'h0,0);
    v[21] = mk(4'h0,4'h0,1,1,32'h1234_5678,4'h0,4'h1,0,0,0,0,32'h0,1);
    // PREADY stuck low: abort after 4 ACCESS cycles
    v[22] = mk(4'h2,4'h0,0,0,32'h0,       4'h2,4'h0,1,0,0,1,32'h0,0);
    v[23] = mk(4'h0,4'h0,0,0,32'h0,       4'h0,4'h0,1,1,0,1,32'h0,0);
    v[24] = mk(4'h0,4'h0,0,0,32'h0,       4'h0,4'h0,1,1,0,1,32'h0,0);
    v[25] = mk(4'h0,4'h0,0,0,32'h0,       4'h0,4'h0,1,1,0,1,32'h0,0);
    v[26] = mk(4'h0,4'h0,0,0,32'h0,       4'h0,4'h0,1,1,0,1,32'h0,0);
    v[27] = mk(4'h0,4'h0,0,0,32'hFFFF_FFFF,4'h0,4'h2,0,0,0,1,32'h0,1);
    // next request served after the abort
    v[28] = mk(4'h4,4'h0,0,0,32'h0,       4'h4,4'h0,1,0,0,2,32'h0,0);
    v[29] = mk(4'h0,4'h0,0,0,32'h0,       4'h0,4'h0,1,1,0,2,32'h0,0);
    v[30] = mk(4'h0,4'h0,1,0,32'h3333_001E,4'h0,4'h4,0,0,0,2,32'h3333_001E,0);

    repeat (2) @(posedge clk);
    #1;
    ok = bus.gnt_o == 0 && bus.rvalid_o == 0
      && bus.rdata_o == 0 && bus.err_o == 0
      && bus.PADDR == 0 && bus.PWDATA == 0
      && bus.PWRITE == 0 && bus.PSEL == 0
      && bus.PENABLE == 0;
    check("reset", ok, outs(), "all zero");
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(v[i].req, v[i].we, v[i].rdy,
            v[i].serr, v[i].prd);
      @(posedge clk);
      #1;
      ok = bus.gnt_o == v[i].e_gnt
        && bus.rvalid_o == v[i].e_rv
        && bus.PSEL == v[i].e_sel
        && bus.PENABLE == v[i].e_en;
      if (v[i].e_sel)
        ok = ok && bus.PADDR == adr(v[i].e_k)
                && bus.PWDATA == wd(v[i].e_k)
                && bus.PWRITE == v[i].e_wr;
      if (v[i].e_rv != 0)
        ok = ok && bus.rdata_o == v[i].e_rd
                && bus.err_o == v[i].e_err;
      check($sformatf("vec%0d", i), ok, outs(),
        $sformatf(
          "g=%h rv=%h sel=%b en=%b wr=%b a=%h wd=%h rd=%h e=%b",
          v[i].e_gnt, v[i].e_rv, v[i].e_sel, v[i].e_en,
          v[i].e_wr, adr(v[i].e_k), wd(v[i].e_k),
          v[i].e_rd, v[i].e_err));
    end

    // reset in the middle of ACCESS
    drive(4'h2, 4'h0, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    check("mid_gnt", bus.gnt_o == 4'h2,
      $sformatf("%h", bus.gnt_o), "2");
    drive(4'h0, 4'h0, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    check("mid_access", bus.PSEL && bus.PENABLE,
      $sformatf("sel=%b en=%b", bus.PSEL, bus.PENABLE),
      "sel=1 en=1");
    rst = 1'b1;
    drive(4'h0, 4'h0, 1'b1, 1'b1, 32'hAAAA_5555);
    @(posedge clk);
    #1;
    ok = bus.gnt_o == 0 && bus.rvalid_o == 0
      && bus.rdata_o == 0 && bus.err_o == 0
      && bus.PADDR == 0 && bus.PWDATA == 0
      && bus.PWRITE == 0 && bus.PSEL == 0
      && bus.PENABLE == 0;
    check("rst_mid", ok, outs(), "all zero");
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_quiet",
      bus.rvalid_o == 0 && bus.PSEL == 0,
      $sformatf("rv=%h sel=%b", bus.rvalid_o, bus.PSEL),
      "rv=0 sel=0");
    drive(4'hF, 4'h0, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    check("rst_ptr",
      bus.gnt_o == 4'h1 && bus.PSEL
        && bus.PADDR == adr(0),
      $sformatf("g=%h sel=%b a=%h",
        bus.gnt_o, bus.PSEL, bus.PADDR),
      $sformatf("g=1 sel=1 a=%h", adr(0)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      n_cmp, n_bad);
    $finish;
  end

endmodule
